// File: rtl/radiant_event_hdr_reader_pkg.sv
// Shared constants, state encoding and address helper for the event header reader.
package radiant_event_hdr_reader_pkg;

    localparam int unsigned WB_ADR_W = 9;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned TO_W     = 8;

    localparam int unsigned                NUM_HDR_DWORDS_DEF = 8;
    localparam logic [WB_ADR_W-1:0]        BASE_ADDR_DEF      = 9'h100;
    localparam logic [WB_DAT_W-1:0]        HDR_IDENT_DEF      = 32'h5244_4530;  // "RDE0"
    localparam int unsigned                ACK_TIMEOUT_DEF    = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUT    = 3'd3,
        ST_POP    = 3'd4,
        ST_SETTLE = 3'd5
    } state_e;

    // Byte address of header dword idx.
    function automatic logic [WB_ADR_W-1:0] hdr_addr(input logic [WB_ADR_W-1:0] base,
                                                     input int unsigned idx);
        return base + WB_ADR_W'(idx << 2);
    endfunction

endpackage

// File: rtl/radiant_event_hdr_reader_if.sv
// Wishbone read bus plus header stream seen by the event header reader.
interface radiant_event_hdr_reader_if;
    import radiant_event_hdr_reader_pkg::*;

    logic                wbm_cyc;
    logic                wbm_stb;
    logic                wbm_we;
    logic [WB_ADR_W-1:0] wbm_adr;
    logic [WB_DAT_W-1:0] wbm_dat;
    logic                wbm_ack;
    logic                wbm_err;

    logic [WB_DAT_W-1:0] hdr_tdata;
    logic                hdr_tvalid;
    logic                hdr_tready;
    logic                hdr_tlast;
    logic                hdr_tuser;

    modport master (
        output wbm_cyc, wbm_stb, wbm_we, wbm_adr,
        input  wbm_dat, wbm_ack, wbm_err,
        output hdr_tdata, hdr_tvalid, hdr_tlast, hdr_tuser,
        input  hdr_tready
    );

    modport slave (
        input  wbm_cyc, wbm_stb, wbm_we, wbm_adr,
        output wbm_dat, wbm_ack, wbm_err,
        input  hdr_tdata, hdr_tvalid, hdr_tlast, hdr_tuser,
        output hdr_tready
    );

endinterface

// File: rtl/radiant_event_hdr_reader.sv
// Reads the event header dwords over wishbone, streams them out, then pops the type FIFO.
module radiant_event_hdr_reader
    import radiant_event_hdr_reader_pkg::*;
#(
    parameter int unsigned         NUM_HDR_DWORDS = NUM_HDR_DWORDS_DEF,
    parameter logic [WB_ADR_W-1:0] BASE_ADDR      = BASE_ADDR_DEF,
    parameter logic [WB_DAT_W-1:0] HDR_IDENT      = HDR_IDENT_DEF,
    parameter int unsigned         ACK_TIMEOUT    = ACK_TIMEOUT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic                      event_ready_i,
    input  logic                      event_type_i,
    output logic                      event_readout_ready_o,
    radiant_event_hdr_reader_if.master bus,
    output logic                      busy_o,
    output logic                      ident_err_o,
    output logic                      bus_err_o,
    output logic [CNT_W-1:0]          event_count_o
);

    localparam int unsigned       IDX_W    = (NUM_HDR_DWORDS > 1) ? $clog2(NUM_HDR_DWORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_HDR_DWORDS - 1);

    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic                cyc_q,       cyc_d;
    logic [WB_ADR_W-1:0] adr_q,       adr_d;
    logic [WB_DAT_W-1:0] tdata_q,     tdata_d;
    logic                tvalid_q,    tvalid_d;
    logic                tlast_q,     tlast_d;
    logic                tuser_q,     tuser_d;
    logic                pop_q,       pop_d;
    logic                busy_q,      busy_d;
    logic                ident_err_q, ident_err_d;
    logic                bus_err_q,   bus_err_d;
    logic [CNT_W-1:0]    count_q,     count_d;

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        to_cnt_d    = to_cnt_q;
        adr_d       = adr_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        ident_err_d = ident_err_q;
        bus_err_d   = bus_err_q;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i && event_ready_i) begin
                    tuser_d = event_type_i;
                    idx_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.wbm_ack) begin
                    tdata_d = bus.wbm_dat;
                    if ((idx_q == '0) && (bus.wbm_dat != HDR_IDENT)) begin
                        ident_err_d = 1'b1;
                    end
                    state_d = ST_OUT;
                end else if (bus.wbm_err || (to_cnt_q == TO_W'(ACK_TIMEOUT))) begin
                    // Failed read still yields a beat so the event keeps its length.
                    tdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (bus.hdr_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_POP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_POP: begin
                count_d = count_q + 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Gives the type FIFO a cycle to reflect the pop before IDLE samples it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs registered against the state they belong to.
        cyc_d    = (state_d == ST_REQ) || (state_d == ST_WAIT);
        tvalid_d = (state_d == ST_OUT);
        tlast_d  = (state_d == ST_OUT) && (idx_d == LAST_IDX);
        pop_d    = (state_d == ST_POP);
        busy_d   = (state_d != ST_IDLE);
        if (state_d == ST_REQ) begin
            adr_d = hdr_addr(BASE_ADDR, 32'(idx_d));
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            pop_q       <= 1'b0;
            busy_q      <= 1'b0;
            ident_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            pop_q       <= pop_d;
            busy_q      <= busy_d;
            ident_err_q <= ident_err_d;
            bus_err_q   <= bus_err_d;
            count_q     <= count_d;
        end
    end

    assign bus.wbm_cyc            = cyc_q;
    assign bus.wbm_stb            = cyc_q;
    assign bus.wbm_we             = 1'b0;
    assign bus.wbm_adr            = adr_q;
    assign bus.hdr_tdata          = tdata_q;
    assign bus.hdr_tvalid         = tvalid_q;
    assign bus.hdr_tlast          = tlast_q;
    assign bus.hdr_tuser          = tuser_q;
    assign event_readout_ready_o  = pop_q;
    assign busy_o                 = busy_q;
    assign ident_err_o            = ident_err_q;
    assign bus_err_o              = bus_err_q;
    assign event_count_o          = count_q;

endmodule

// File: doc/radiant_event_hdr_reader.md
Name: radiant_event_hdr_reader

Overview:
Downstream consumer of the event control core's DMA-request path, running in the wishbone clock domain. When an event is pending (event_ready), it acts as a wishbone master and reads the event header dwords at 0x100-0x11C. It streams them out as a 32-bit valid/ready header stream with last/type sideband, then pops the type FIFO with a one-cycle readout-ready pulse. It sits between the event control core and the DMA/packet builder.

Parameters:
NUM_HDR_DWORDS, 8, header dwords read per event (addresses BASE_ADDR + 4*n)
BASE_ADDR, 9'h100, wishbone byte address of header dword 0
HDR_IDENT, 32'h52444530, expected dword 0 value ("RDE0")
ACK_TIMEOUT, 255, cycles to wait for ack/err before aborting a read (8-bit counter)

Ports:
clk_i  in  1  wishbone/system clock; all logic in this domain
rst_n_i  in  1  synchronous, active-low reset
enable_i  in  1  permit starting new events
event_ready_i  in  1  event pending (type FIFO valid)
event_type_i  in  1  type of pending event
event_readout_ready_o  out  1  1-cycle pop pulse to type FIFO
wbm_cyc_o  out  1  wishbone cycle
wbm_stb_o  out  1  wishbone strobe
wbm_we_o  out  1  always 0
wbm_adr_o  out  9  byte address
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  ack
wbm_err_i  in  1  error
hdr_tdata_o  out  32  header dword
hdr_tvalid_o  out  1  data valid
hdr_tready_i  in  1  sink ready
hdr_tlast_o  out  1  marks last dword of event
hdr_tuser_o  out  1  event type latched at event start
busy_o  out  1  not in IDLE
ident_err_o  out  1  sticky: dword 0 != HDR_IDENT
bus_err_o  out  1  sticky: err or timeout seen
event_count_o  out  16  events completed, wraps

Behaviour:
- Reset (rst_n_i=0 at clk edge): FSM to IDLE; all outputs 0; sticky flags and event_count cleared; word index 0. Takes effect mid-transfer: cyc/stb drop next cycle, no pop issued.
- IDLE: if enable_i && event_ready_i -> latch event_type_i into hdr_tuser_o, index=0, go REQ.
- REQ: assert cyc/stb, adr = BASE_ADDR + 4*index; go WAIT.
- WAIT: hold cyc/stb/adr. On ack_i: capture dat_i, drop cyc/stb next cycle (exactly one ack per read; the slave pops its FIFO on ack), go OUT. On err_i or timeout counter == ACK_TIMEOUT: set bus_err, drop cyc/stb, capture 32'h0, go OUT. In both cases continue the event with the remaining words.
- Index 0 capture: if value != HDR_IDENT, set ident_err (sticky); the dword is still streamed.
- OUT: tvalid=1, tdata stable, tlast = (index==NUM_HDR_DWORDS-1). On tvalid&&tready: if last -> POP, else index+1 -> REQ. Min per-word latency: REQ->WAIT->ack (slave acks 1 cycle after stb) ->OUT = 3-4 cycles.
- POP: event_readout_ready_o=1 for exactly one cycle, event_count+1 (16-bit wrap 0xFFFF->0). Go SETTLE.
- SETTLE: one idle cycle so event_ready_i reflects the pop, then IDLE.
- enable_i deassert mid-event: current event finishes including pop; no new start.
- event_ready_i dropping mid-event: ignored; the event completes and the pop is still issued.
- Backpressure: tdata/tlast/tuser held stable while tvalid && !tready; no WB activity during OUT.
- busy_o = (state != IDLE).

Decomposition:
- Shared package/header: HDR_IDENT constant, BASE_ADDR, state encoding (IDLE, REQ, WAIT, OUT, POP, SETTLE).
- No sub-module. The wishbone read logic is inline; a separate single-read master is not warranted at this size.

Test Plan:
- Single event with slave acking 1 cycle after stb, tready=1: reads at 0x100..0x11C in order, 8 beats, tlast on beat 8, dword0 = 0x52444530, one pop pulse, event_count=1, ident_err=0.
- Three queued events: exactly 3 pops, 24 beats, tuser matches each event's type (e.g. 0,1,0), SETTLE cycle present between events.
- tready toggled 1/0 each cycle: data is stable across stalls, no extra WB reads, beat order is preserved.
- Slave returns 0xDEADBEEF at dword 0: ident_err=1 sticky, event still completes and pops.
- Slave withholds ack on dword 3 with ACK_TIMEOUT=15: after 15 cycles bus_err=1, beat 4 = 0x0, remaining reads proceed, pop issued.
- Reset asserted in WAIT: next cycle cyc/stb=0, tvalid=0, no pop, counters cleared; after release a pending event restarts at 0x100.
